// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative signed/unsigned multiply/divide unit for the HI/LO path.
// Retires STEP bits per RUN cycle; result_o is {hi,lo}. A divide leaves the
// quotient in lo and the remainder in hi.
// Optional build macro: MULDIV_EARLY_EXIT_EN lets a multiply finish as soon as
// the remaining multiplier bits are zero.
// Handshake: start_i is held high until ready_o is seen. The unit then stays in
// DONE until start_i drops. annul_i aborts from any state.
module ex_muldiv #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               is_div_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o,
    output logic               busy_o
);
    localparam int ITERS = WIDTH / STEP;
    localparam int CW    = $clog2(ITERS + 1);

    generate
        if (!(STEP == 1 || STEP == 2 || STEP == 4) || (WIDTH % STEP) != 0) begin : g_bad_step
            $error("ex_muldiv: STEP must be 1, 2 or 4 and must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    // acc: product accumulator (mult) or {remainder, shifting quotient} (div)
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // mcand: multiplicand shifting left (mult) or divisor in the low half (div)
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               opa_neg, opb_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] it_acc, it_mcand;
    logic [WIDTH-1:0]   it_mplier;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quo, rem;
    logic [2*WIDTH-1:0] fin;
    logic               last;

    // Signed operands are turned into magnitudes at accept; signs are applied at the end.
    assign opa_neg = signed_i & opa_i[WIDTH-1];
    assign opb_neg = signed_i & opb_i[WIDTH-1];
    assign mag_a   = opa_neg ? -opa_i : opa_i;
    assign mag_b   = opb_neg ? -opb_i : opb_i;

    // One RUN cycle: STEP shift-add (mult) or restoring subtract-shift (div) iterations.
    always_comb begin
        it_acc    = acc_q;
        it_mcand  = mcand_q;
        it_mplier = mplier_q;
        trial     = '0;
        for (int i = 0; i < STEP; i++) begin
            if (is_div_q) begin
                trial = {it_acc[2*WIDTH-1:WIDTH], it_acc[WIDTH-1]} - {1'b0, it_mcand[WIDTH-1:0]};
                if (trial[WIDTH]) begin
                    it_acc = {it_acc[2*WIDTH-2:0], 1'b0};
                end else begin
                    it_acc = {trial[WIDTH-1:0], it_acc[WIDTH-2:0], 1'b1};
                end
            end else begin
                if (it_mplier[0]) begin
                    it_acc = it_acc + it_mcand;
                end
                it_mcand  = it_mcand << 1;
                it_mplier = it_mplier >> 1;
            end
        end
    end

    // Sign correction of the value produced by the current iteration.
    always_comb begin
        quo = it_acc[WIDTH-1:0];
        rem = it_acc[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            fin = {(neg_rem_q ? -rem : rem), (neg_res_q ? -quo : quo)};
        end else begin
            fin = neg_res_q ? -it_acc : it_acc;
        end
    end

`ifdef MULDIV_EARLY_EXIT_EN
    assign last = (cnt_q == CW'(ITERS - 1)) || (!is_div_q && (it_mplier == '0));
`else
    assign last = (cnt_q == CW'(ITERS - 1));
`endif

    // Next-state and datapath-load logic; annul_i overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    is_div_d  = is_div_i;
                    neg_res_d = opa_neg ^ opb_neg;
                    neg_rem_d = opa_neg;
                    cnt_d     = '0;
                    acc_d     = is_div_i ? {{WIDTH{1'b0}}, mag_a} : '0;
                    mcand_d   = {{WIDTH{1'b0}}, (is_div_i ? mag_b : mag_a)};
                    mplier_d  = mag_b;
                    if (is_div_i && (opb_i == '0)) begin
                        result_d = {opa_i, {WIDTH{1'b1}}};
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d    = it_acc;
                mcand_d  = it_mcand;
                mplier_d = it_mplier;
                cnt_d    = cnt_q + CW'(1);
                if (last) begin
                    result_d = fin;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (!start_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (annul_i) begin
            state_d  = S_IDLE;
            result_d = '0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            result_q  <= result_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = !rst && (state_q == S_DONE);
    assign busy_o     = !rst && (state_q != S_IDLE);
    assign stallreq_o = !rst && (((state_q == S_IDLE) && start_i && !annul_i) || (state_q == S_RUN));

endmodule
